rf_wb_arbiter: RTL and testbench

Writeback arbiter placed in front of the register file's single write port. It merges one non-stallable single-cycle result stream (ALU) with two valid/ready result streams (load/store unit, multiply/divide unit) through a shared in-order queue. It drives registered rf_wen/rf_waddr/rf_wdata and exports a pending-write mask that decode uses for hazard detection.

---
 rtl/rf_wb_arbiter.sv | 125 ++++++++++++
 tb/tb_rf_wb_arbiter.sv | 328 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rf_wb_arbiter.sv
// rtl/rf_wb_arbiter.sv - writeback arbiter: ALU direct path plus shared in-order queue for LSU/MUL-DIV
// Drives the single register-file write port and exposes pending destination registers.
module rf_wb_arbiter #(
  parameter int XLEN          = 32,
  parameter int RF_ADDR_WIDTH = 5,
  parameter int REG_NUM       = 32,
  parameter int QDEPTH        = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     alu_valid,
  input  logic [RF_ADDR_WIDTH-1:0] alu_rd,
  input  logic [XLEN-1:0]          alu_data,
  input  logic                     lsu_valid,
  output logic                     lsu_ready,
  input  logic [RF_ADDR_WIDTH-1:0] lsu_rd,
  input  logic [XLEN-1:0]          lsu_data,
  input  logic                     md_valid,
  output logic                     md_ready,
  input  logic [RF_ADDR_WIDTH-1:0] md_rd,
  input  logic [XLEN-1:0]          md_data,
  output logic                     rf_wen,
  output logic [RF_ADDR_WIDTH-1:0] rf_waddr,
  output logic [XLEN-1:0]          rf_wdata,
  output logic [REG_NUM-1:0]       pend_mask,
  output logic [$clog2(QDEPTH):0]  q_count
);

  localparam int PW = $clog2(QDEPTH);
  localparam int CW = PW + 1;

  logic [RF_ADDR_WIDTH-1:0] q_rd_q   [QDEPTH];
  logic [XLEN-1:0]          q_data_q [QDEPTH];

  logic [PW-1:0]            wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]            count_q, count_d;
  logic                     rr_q, rr_d;
  logic                     rf_wen_q, rf_wen_d;
  logic [RF_ADDR_WIDTH-1:0] rf_waddr_q, rf_waddr_d;
  logic [XLEN-1:0]          rf_wdata_q, rf_wdata_d;

  logic                     full, empty, grant_lsu, grant_md;
  logic                     enq_lsu, enq_md, enq, pop;
  logic [RF_ADDR_WIDTH-1:0] enq_rd;
  logic [XLEN-1:0]          enq_data;
  logic [PW-1:0]            idx;

  always_comb begin
    full      = (count_q == CW'(QDEPTH));
    empty     = (count_q == '0);
    // rr_q=0 prefers LSU, rr_q=1 prefers MD; only consulted when both are valid
    grant_lsu = lsu_valid & (~md_valid | ~rr_q);
    grant_md  = md_valid & (~lsu_valid | rr_q);
    lsu_ready = grant_lsu & ~full;
    md_ready  = grant_md & ~full;
    enq_lsu   = lsu_valid & lsu_ready;
    enq_md    = md_valid & md_ready;
    enq       = enq_lsu | enq_md;
    pop       = ~alu_valid & ~empty;
    enq_rd    = enq_md ? md_rd : lsu_rd;
    enq_data  = enq_md ? md_data : lsu_data;

    wr_ptr_d  = wr_ptr_q + PW'(enq);
    rd_ptr_d  = rd_ptr_q + PW'(pop);
    count_d   = count_q + CW'(enq) - CW'(pop);
    rr_d      = (lsu_valid & md_valid & enq) ? ~rr_q : rr_q;

    rf_wen_d   = 1'b0;
    rf_waddr_d = rf_waddr_q;
    rf_wdata_d = rf_wdata_q;
    if (alu_valid) begin
      rf_wen_d   = (alu_rd != '0);
      rf_waddr_d = alu_rd;
      rf_wdata_d = alu_data;
    end else if (!empty) begin
      rf_wen_d   = (q_rd_q[rd_ptr_q] != '0);
      rf_waddr_d = q_rd_q[rd_ptr_q];
      rf_wdata_d = q_data_q[rd_ptr_q];
    end
  end

  // Pending mask walks only the occupied slots, so stale storage never leaks in
  always_comb begin
    pend_mask = '0;
    idx       = '0;
    for (int i = 0; i < QDEPTH; i++) begin
      idx = rd_ptr_q + PW'(i);
      if (CW'(i) < count_q) pend_mask[q_rd_q[idx]] = 1'b1;
    end
    pend_mask[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      rr_q       <= 1'b0;
      rf_wen_q   <= 1'b0;
      rf_waddr_q <= '0;
      rf_wdata_q <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      rr_q       <= rr_d;
      rf_wen_q   <= rf_wen_d;
      rf_waddr_q <= rf_waddr_d;
      rf_wdata_q <= rf_wdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (enq) begin
      q_rd_q[wr_ptr_q]   <= enq_rd;
      q_data_q[wr_ptr_q] <= enq_data;
    end
  end

  assign rf_wen   = rf_wen_q;
  assign rf_waddr = rf_waddr_q;
  assign rf_wdata = rf_wdata_q;
  assign q_count  = count_q;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// tb/tb_rf_wb_arbiter.sv - self-checking bench for rf_wb_arbiter
// Directed scenarios plus randomized traffic against a queue-based reference model.
module tb_rf_wb_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        alu_valid, lsu_valid, md_valid;
  logic [4:0]  alu_rd, lsu_rd, md_rd;
  logic [31:0] alu_data, lsu_data, md_data;
  logic        lsu_ready, md_ready, rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata, pend_mask;
  logic [2:0]  q_count;

  int checks = 0;
  int errors = 0;

  rf_wb_arbiter #(.XLEN(32), .RF_ADDR_WIDTH(5), .REG_NUM(32), .QDEPTH(4)) dut (
    .clk(clk), .rst(rst),
    .alu_valid(alu_valid), .alu_rd(alu_rd), .alu_data(alu_data),
    .lsu_valid(lsu_valid), .lsu_ready(lsu_ready), .lsu_rd(lsu_rd), .lsu_data(lsu_data),
    .md_valid(md_valid), .md_ready(md_ready), .md_rd(md_rd), .md_data(md_data),
    .rf_wen(rf_wen), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .pend_mask(pend_mask), .q_count(q_count)
  );

  always #5 clk = ~clk;

  // Reference model: an ordered list of queued writes and a preferred-source flag
  typedef struct { logic [4:0] rd; logic [31:0] d; } ent_t;
  ent_t        mq[$];
  bit          m_pref_md;
  logic        m_wen, m_lr, m_mr;
  logic [4:0]  m_waddr;
  logic [31:0] m_wdata;
  bit          l_xfer, m_xfer;

  function void model_reset();
    mq.delete();
    m_pref_md = 0;
    m_wen = 0; m_waddr = '0; m_wdata = '0;
    l_xfer = 1; m_xfer = 1;
  endfunction

  function void model_ready();
    bit give_l, give_m;
    give_l = lsu_valid && (!md_valid || !m_pref_md);
    give_m = md_valid && (!lsu_valid || m_pref_md);
    m_lr = give_l && (mq.size() < 4);
    m_mr = give_m && (mq.size() < 4);
  endfunction

  function void model_step();
    ent_t e;
    model_ready();
    l_xfer = lsu_valid && m_lr;
    m_xfer = md_valid && m_mr;
    if (alu_valid) begin
      m_wen = (alu_rd != 0); m_waddr = alu_rd; m_wdata = alu_data;
    end else if (mq.size() > 0) begin
      e = mq.pop_front();
      m_wen = (e.rd != 0); m_waddr = e.rd; m_wdata = e.d;
    end else begin
      m_wen = 0;
    end
    if (l_xfer) begin e.rd = lsu_rd; e.d = lsu_data; mq.push_back(e); end
    if (m_xfer) begin e.rd = md_rd; e.d = md_data; mq.push_back(e); end
    if (lsu_valid && md_valid && (l_xfer || m_xfer)) m_pref_md = !m_pref_md;
  endfunction

  function logic [31:0] model_mask();
    logic [31:0] m;
    m = '0;
    foreach (mq[i]) m[mq[i].rd] = 1'b1;
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic clear_inputs();
    alu_valid = 0; lsu_valid = 0; md_valid = 0;
    alu_rd = 0; lsu_rd = 0; md_rd = 0;
    alu_data = 0; lsu_data = 0; md_data = 0;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    model_reset();
    @(negedge clk);
    rst = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1;
    clear_inputs();
    model_reset();
    #1;
    if (rf_wen !== 1'b0) begin errors++; $display("FAIL reset_wen got %b exp 0", rf_wen); end
    checks++;
    if (rf_waddr !== 5'd0 || rf_wdata !== 32'd0) begin errors++; $display("FAIL reset_addr_data got %h/%h exp 0/0", rf_waddr, rf_wdata); end
    checks++;
    @(negedge clk);
    rst = 0;
    #1;
    if (q_count !== 3'd0 || pend_mask !== 32'd0) begin errors++; $display("FAIL reset_queue got cnt %0d mask %h exp 0/0", q_count, pend_mask); end
    checks++;
    if (lsu_ready !== 1'b0 || md_ready !== 1'b0) begin errors++; $display("FAIL reset_ready got %b%b exp 00", lsu_ready, md_ready); end
    checks++;
  endtask

  task automatic test_alu();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 5; alu_data = 32'h1234;
    tick();
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL alu_write got %b %0d %h exp 1 5 1234", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
    @(negedge clk);
    alu_valid = 0; alu_rd = 9; alu_data = 32'hdead;
    tick();
    if (rf_wen !== 1'b0 || rf_waddr !== 5'd5 || rf_wdata !== 32'h1234) begin
      errors++; $display("FAIL alu_hold got %b %0d %h exp 0 5 1234", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
  endtask

  task automatic test_lsu_single();
    do_reset();
    @(negedge clk);
    lsu_valid = 1; lsu_rd = 3; lsu_data = 32'hAA;
    #1;
    if (lsu_ready !== 1'b1 || md_ready !== 1'b0) begin errors++; $display("FAIL lsu_ready got %b%b exp 10", lsu_ready, md_ready); end
    checks++;
    tick();
    @(negedge clk);
    lsu_valid = 0;
    #1;
    if (pend_mask !== 32'h8 || q_count !== 3'd1 || rf_wen !== 1'b0) begin
      errors++; $display("FAIL lsu_pending got mask %h cnt %0d wen %b exp 8 1 0", pend_mask, q_count, rf_wen);
    end
    checks++;
    tick();
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hAA || pend_mask !== 32'd0 || q_count !== 3'd0) begin
      errors++; $display("FAIL lsu_retire got %b %0d %h mask %h cnt %0d exp 1 3 aa 0 0", rf_wen, rf_waddr, rf_wdata, pend_mask, q_count);
    end
    checks++;
  endtask

  task automatic test_contention();
    int ln = 0;
    int mn = 0;
    int exp_rd[4] = '{20, 11, 21, 22};
    do_reset();
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      alu_valid = 1; alu_rd = 7; alu_data = k;
      lsu_valid = 1; lsu_rd = 5'(10 + ln); lsu_data = 32'h100 + 10 + ln;
      md_valid  = 1; md_rd  = 5'(20 + mn); md_data  = 32'h100 + 20 + mn;
      #1;
      if (k < 4) begin
        if (lsu_ready !== (k % 2 == 0) || md_ready !== (k % 2 == 1)) begin
          errors++; $display("FAIL rr_grant%0d got %b%b exp %b%b", k, lsu_ready, md_ready, k % 2 == 0, k % 2 == 1);
        end
      end else begin
        if (lsu_ready !== 1'b0 || md_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b%b exp 00", lsu_ready, md_ready); end
      end
      checks++;
      tick();
      if (k < 4) begin
        if (k % 2 == 0) ln++; else mn++;
      end
    end
    if (q_count !== 3'd4 || rf_waddr !== 5'd7) begin errors++; $display("FAIL full_count got %0d addr %0d exp 4 7", q_count, rf_waddr); end
    checks++;
    @(negedge clk);
    alu_valid = 0; lsu_valid = 0;
    #1;
    if (md_ready !== 1'b0) begin errors++; $display("FAIL no_bypass got %b exp 0", md_ready); end
    checks++;
    tick();
    if (q_count !== 3'd3 || rf_wen !== 1'b1 || rf_waddr !== 5'd10) begin
      errors++; $display("FAIL pop_while_full got cnt %0d wen %b addr %0d exp 3 1 10", q_count, rf_wen, rf_waddr);
    end
    checks++;
    @(negedge clk);
    alu_valid = 1;
    #1;
    if (md_ready !== 1'b1) begin errors++; $display("FAIL refill_ready got %b exp 1", md_ready); end
    checks++;
    tick();
    if (q_count !== 3'd4) begin errors++; $display("FAIL refill_count got %0d exp 4", q_count); end
    checks++;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      alu_valid = 0; md_valid = 0;
      tick();
      if (rf_wen !== 1'b1 || rf_waddr !== 5'(exp_rd[i]) || rf_wdata !== 32'h100 + exp_rd[i] || q_count !== 3'(3 - i)) begin
        errors++; $display("FAIL drain%0d got %b %0d %h cnt %0d exp 1 %0d %h %0d", i, rf_wen, rf_waddr, rf_wdata, q_count,
                           exp_rd[i], 32'h100 + exp_rd[i], 3 - i);
      end
      checks++;
    end
  endtask

  task automatic test_x0();
    do_reset();
    @(negedge clk);
    alu_valid = 1; alu_rd = 0; alu_data = 32'h55;
    tick();
    if (rf_wen !== 1'b0 || pend_mask[0] !== 1'b0) begin errors++; $display("FAIL x0_alu got wen %b mask0 %b exp 0 0", rf_wen, pend_mask[0]); end
    checks++;
    @(negedge clk);
    alu_valid = 0; lsu_valid = 1; lsu_rd = 0; lsu_data = 32'h66;
    #1;
    if (lsu_ready !== 1'b1) begin errors++; $display("FAIL x0_accept got %b exp 1", lsu_ready); end
    checks++;
    tick();
    if (q_count !== 3'd1 || pend_mask !== 32'd0) begin errors++; $display("FAIL x0_queued got cnt %0d mask %h exp 1 0", q_count, pend_mask); end
    checks++;
    @(negedge clk);
    lsu_valid = 0;
    tick();
    if (rf_wen !== 1'b0 || q_count !== 3'd0) begin errors++; $display("FAIL x0_pop got wen %b cnt %0d exp 0 0", rf_wen, q_count); end
    checks++;
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      alu_valid = 1; alu_rd = 9; alu_data = k;
      lsu_valid = 1; lsu_rd = 5'(12 + k); lsu_data = 32'h200 + k;
      tick();
    end
    if (q_count !== 3'd3 || pend_mask !== 32'h7000 || rf_wen !== 1'b1) begin
      errors++; $display("FAIL pre_reset got cnt %0d mask %h wen %b exp 3 7000 1", q_count, pend_mask, rf_wen);
    end
    checks++;
    #1;
    rst = 1;
    model_reset();
    #1;
    if (rf_wen !== 1'b0 || q_count !== 3'd0 || pend_mask !== 32'd0) begin
      errors++; $display("FAIL async_reset got wen %b cnt %0d mask %h exp 0 0 0", rf_wen, q_count, pend_mask);
    end
    checks++;
    @(negedge clk);
    clear_inputs();
    @(negedge clk);
    rst = 0;
    lsu_valid = 1; lsu_rd = 4; lsu_data = 32'h44;
    md_valid = 1; md_rd = 6; md_data = 32'h66;
    #1;
    if (lsu_ready !== 1'b1 || md_ready !== 1'b0) begin errors++; $display("FAIL post_reset_rr got %b%b exp 10", lsu_ready, md_ready); end
    checks++;
    tick();
    if (rf_wen !== 1'b0 || q_count !== 3'd1) begin errors++; $display("FAIL no_stale got wen %b cnt %0d exp 0 1", rf_wen, q_count); end
    checks++;
    @(negedge clk);
    lsu_valid = 0;
    tick();
    if (rf_wen !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h44) begin
      errors++; $display("FAIL post_reset_write got %b %0d %h exp 1 4 44", rf_wen, rf_waddr, rf_wdata);
    end
    checks++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      alu_valid = ($urandom_range(0, 9) < 3);
      alu_rd = 5'($urandom_range(0, 7));
      alu_data = $urandom;
      if (!(lsu_valid && !l_xfer)) begin
        lsu_valid = $urandom_range(0, 1);
        lsu_rd = 5'($urandom_range(0, 7));
        lsu_data = $urandom;
      end
      if (!(md_valid && !m_xfer)) begin
        md_valid = $urandom_range(0, 1);
        md_rd = 5'($urandom_range(0, 7));
        md_data = $urandom;
      end
      #1;
      model_ready();
      if (lsu_ready !== m_lr || md_ready !== m_mr) begin
        errors++; $display("FAIL rnd_ready c%0d got %b%b exp %b%b", c, lsu_ready, md_ready, m_lr, m_mr);
      end
      checks++;
      tick();
      if (rf_wen !== m_wen || rf_waddr !== m_waddr || rf_wdata !== m_wdata) begin
        errors++; $display("FAIL rnd_write c%0d got %b %0d %h exp %b %0d %h", c, rf_wen, rf_waddr, rf_wdata, m_wen, m_waddr, m_wdata);
      end
      checks++;
      if (pend_mask !== model_mask() || q_count !== 3'(mq.size())) begin
        errors++; $display("FAIL rnd_queue c%0d got mask %h cnt %0d exp %h %0d", c, pend_mask, q_count, model_mask(), mq.size());
      end
      checks++;
    end
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    model_reset();
    test_reset();
    test_alu();
    test_lsu_single();
    test_contention();
    test_x0();
    test_async_reset();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
